// File: rtl/sr_cmd_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_debouncer
// Purpose  : Debounces raw set/clear buttons into one-cycle SR command pulses.
// Revision : 1.0
// ============================================================================
module sr_cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_btn_i,
  input  logic             clr_btn_i,
  output logic             s_o,
  output logic             r_o,
  output logic             conflict_o,
  output logic [CNT_W-1:0] event_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONF_HI = 2'd1,
    HIGH    = 2'd2,
    CONF_LO = 2'd3
  } state_t;

  localparam logic [7:0] C_DEB = 8'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] raw;
  logic [1:0] rise;

  assign raw = {clr_btn_i, set_btn_i};

  // Channel 0 is set, channel 1 is clear.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      logic       sync1_q;
      logic       sync2_q;
      state_t     state_q;
      state_t     state_d;
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;
      logic [7:0] cnt_inc;
      logic       rise_d;

      assign cnt_inc = cnt_q + 8'd1;

      // The sample that takes the count to DEBOUNCE_CYCLES is the one that
      // accepts the edge, so acceptance happens on that same clock.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        case (state_q)
          IDLE: begin
            if (sync2_q) begin
              state_d = CONF_HI;
              cnt_d   = 8'd1;
            end
          end
          CONF_HI: begin
            if (!sync2_q) begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end else if (cnt_inc >= C_DEB) begin
              state_d = HIGH;
              cnt_d   = 8'd0;
              rise_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          HIGH: begin
            if (!sync2_q) begin
              state_d = CONF_LO;
              cnt_d   = 8'd1;
            end
          end
          CONF_LO: begin
            if (sync2_q) begin
              state_d = HIGH;
              cnt_d   = 8'd0;
            end else if (cnt_inc >= C_DEB) begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end else begin
          sync1_q <= raw[g];
          sync2_q <= sync1_q;
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign rise[g] = rise_d;
    end
  endgenerate

  logic             s_q;
  logic             s_d;
  logic             r_q;
  logic             r_d;
  logic             conflict_q;
  logic             conflict_d;
  logic [CNT_W-1:0] event_cnt_q;
  logic [CNT_W-1:0] event_cnt_d;

  // Clear has priority when both channels accept on the same edge.
  always_comb begin
    s_d         = rise[0] & ~rise[1];
    r_d         = rise[1];
    conflict_d  = rise[0] & rise[1];
    event_cnt_d = event_cnt_q;
    if (rise[0] | rise[1]) begin
      event_cnt_d = event_cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      conflict_q  <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      s_q         <= s_d;
      r_q         <= r_d;
      conflict_q  <= conflict_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign s_o         = s_q;
  assign r_o         = r_q;
  assign conflict_o  = conflict_q;
  assign event_cnt_o = event_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_cmd_debouncer
// Purpose  : Scoreboard bench for the SR command debouncer.
// Revision : 1.0
// ============================================================================
module tb_sr_cmd_debouncer;

  localparam int DEB = 4;
  localparam int LAT = DEB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic       s_o;
  logic       r_o;
  logic       conflict_o;
  logic [7:0] event_cnt_o;

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .set_btn_i  (set_btn),
    .clr_btn_i  (clr_btn),
    .s_o        (s_o),
    .r_o        (r_o),
    .conflict_o (conflict_o),
    .event_cnt_o(event_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int   at;
    logic s;
    logic r;
    logic cf;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_cnt = 8'd0;
  bit         mon_en = 1'b0;

  // Every cycle out of reset: either the expected pulse or all-quiet outputs.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse edge %0d: expected pulse never seen", mon_e.at);
        model_cnt = model_cnt + 8'd1;
      end
      if (sb.size() > 0 && sb[0].at == cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if ({s_o, r_o, conflict_o} !== {mon_e.s, mon_e.r, mon_e.cf}) begin
          errors++;
          $display("FAIL pulse edge %0d: s/r/cf got %b%b%b want %b%b%b", cyc,
                   s_o, r_o, conflict_o, mon_e.s, mon_e.r, mon_e.cf);
        end
        model_cnt = model_cnt + 8'd1;
      end else begin
        checks++;
        if ({s_o, r_o, conflict_o} !== 3'b000) begin
          errors++;
          $display("FAIL quiet edge %0d: s/r/cf got %b%b%b want 000", cyc,
                   s_o, r_o, conflict_o);
        end
      end
      checks++;
      if (event_cnt_o !== model_cnt) begin
        errors++;
        $display("FAIL event_cnt edge %0d: got %0d want %0d", cyc, event_cnt_o, model_cnt);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at, input logic s, input logic r, input logic cf);
    exp_t e;
    e.at = at;
    e.s  = s;
    e.r  = r;
    e.cf = cf;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 40) begin
      step(1);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected pulses outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({s_o, r_o, conflict_o} !== 3'b000 || event_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL %s: s/r/cf=%b%b%b cnt=%0d want 000 cnt=0", name,
               s_o, r_o, conflict_o, event_cnt_o);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    model_cnt = 8'd0;
    #1;
    check_quiet("reset_async");
    step(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step(3);
    check_quiet("reset_state");
    rst = 1'b0;
    mon_en = 1'b1;
    step(5);
  endtask

  task automatic test_clean_set();
    set_btn = 1'b1;
    expect_pulse(cyc + 1 + LAT, 1'b1, 1'b0, 1'b0);
    step(20);
    set_btn = 1'b0;
    step(12);
    drain();
  endtask

  task automatic test_bounce();
    clr_btn = 1'b1; step(1);
    clr_btn = 1'b0; step(1);
    clr_btn = 1'b1; step(1);
    clr_btn = 1'b0; step(1);
    clr_btn = 1'b1;
    expect_pulse(cyc + 1 + LAT, 1'b0, 1'b1, 1'b0);
    step(15);
    clr_btn = 1'b0;
    step(12);
    drain();
  endtask

  task automatic test_simultaneous();
    set_btn = 1'b1;
    clr_btn = 1'b1;
    expect_pulse(cyc + 1 + LAT, 1'b0, 1'b1, 1'b1);
    step(15);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    step(12);
    drain();
  endtask

  task automatic test_hold_repress();
    logic [7:0] want;
    want = model_cnt + 8'd2;
    set_btn = 1'b1;
    expect_pulse(cyc + 1 + LAT, 1'b1, 1'b0, 1'b0);
    step(50);
    set_btn = 1'b0;
    step(10);
    set_btn = 1'b1;
    expect_pulse(cyc + 1 + LAT, 1'b1, 1'b0, 1'b0);
    step(15);
    set_btn = 1'b0;
    step(12);
    drain();
    checks++;
    if (event_cnt_o !== want) begin
      errors++;
      $display("FAIL hold_repress_cnt: got %0d want %0d", event_cnt_o, want);
    end
  endtask

  task automatic test_mid_reset();
    set_btn = 1'b1;
    step(5);
    rst = 1'b1;
    #1;
    check_quiet("mid_reset_async");
    sb.delete();
    model_cnt = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_pulse(cyc + 1 + LAT, 1'b1, 1'b0, 1'b0);
    step(15);
    set_btn = 1'b0;
    step(12);
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    step(2);
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) begin
        set_btn = 1'b1;
        expect_pulse(cyc + 1 + LAT, 1'b1, 1'b0, 1'b0);
      end else begin
        clr_btn = 1'b1;
        expect_pulse(cyc + 1 + LAT, 1'b0, 1'b1, 1'b0);
      end
      step(9);
      set_btn = 1'b0;
      clr_btn = 1'b0;
      step(8);
    end
    drain();
    checks++;
    if (event_cnt_o !== 8'h00) begin
      errors++;
      $display("FAIL wrap_cnt: got 0x%02h want 0x00", event_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_clean_set();
    test_bounce();
    test_simultaneous();
    test_hold_repress();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
